lcd_hd44780_ctrl: RTL and testbench

- Consumer end of the memory-mapped LCD output register.
- Takes each 32-bit word stored to the LCD window (0x1000_4000–0x1000_4FFF) and turns it into one correctly timed HD44780 bus cycle: RS/DATA setup, EN pulse, hold, then execution wait.
- Software no longer bit-bangs EN. Busy and overflow status are returned for load-path readback.

---
 rtl/lcd_hd44780_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_lcd_hd44780_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 bus-cycle engine: turns each LCD-window store into a timed RS/DATA/EN sequence.
// Optional power-on init sequence is enabled with the LCD_INIT_EN macro.
module lcd_hd44780_ctrl #(
  parameter int unsigned T_SETUP     = 4,
  parameter int unsigned T_PW        = 12,
  parameter int unsigned T_HOLD      = 4,
  parameter int unsigned T_EXEC      = 1850,
  parameter int unsigned T_EXEC_LONG = 82000,
  parameter int unsigned T_POWERUP   = 750000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_data,
  input  logic        i_stat_clr,
  output logic [31:0] o_status,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned T_MAX = max2(max2(max2(T_SETUP, T_PW), max2(T_HOLD, T_EXEC)),
                                       max2(T_EXEC_LONG, T_POWERUP));
  localparam int CW = $clog2(T_MAX) + 1;

  localparam logic [CW-1:0] CNT_SETUP     = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] CNT_PW        = CW'(T_PW - 1);
  localparam logic [CW-1:0] CNT_HOLD      = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] CNT_EXEC      = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] CNT_EXEC_LONG = CW'(T_EXEC_LONG - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4
`ifdef LCD_INIT_EN
    , ST_INIT_WAIT = 3'd5
`endif
  } state_t;

`ifdef LCD_INIT_EN
  localparam state_t        RST_STATE = ST_INIT_WAIT;
  localparam logic [CW-1:0] RST_CNT   = CW'(T_POWERUP - 1);
`else
  localparam state_t        RST_STATE = ST_IDLE;
  localparam logic [CW-1:0] RST_CNT   = '0;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      cur_byte_q, cur_byte_d;
  logic            cur_rs_q, cur_rs_d;
  logic            hold_vld_q, hold_vld_d;
  logic [7:0]      hold_byte_q, hold_byte_d;
  logic            hold_rs_q, hold_rs_d;
  logic            ovf_q, ovf_d;
  logic            lcd_on_q, lcd_on_d;
  logic            lcd_en_q, lcd_en_d;
  logic            busy;
  logic            init_pend;
  logic            long_wait;
  logic            wr_direct;
  logic            hold_free;
  logic            unused_wr_bits;

  assign unused_wr_bits = ^i_wr_data[30:9];

`ifdef LCD_INIT_EN
  logic [2:0] init_idx_q, init_idx_d;
  logic [7:0] init_byte;

  always_comb begin
    case (init_idx_q)
      3'd0:    init_byte = 8'h38;
      3'd1:    init_byte = 8'h0C;
      3'd2:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  end

  assign init_pend = (init_idx_q < 3'd4);
`else
  assign init_pend = 1'b0;
`endif

  // Clear/Home (and the undefined 0x00) need the long execution time.
  assign long_wait = !cur_rs_q && (cur_byte_q <= 8'h03);
  assign wr_direct = i_wr_en && (state_q == ST_IDLE) && !hold_vld_q && !init_pend;
  // In IDLE the hold entry is being drained this cycle, so it can take a new write.
  assign hold_free = !hold_vld_q || ((state_q == ST_IDLE) && !init_pend);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= RST_STATE;
      cnt_q       <= RST_CNT;
      cur_byte_q  <= '0;
      cur_rs_q    <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_byte_q <= '0;
      hold_rs_q   <= 1'b0;
      ovf_q       <= 1'b0;
      lcd_on_q    <= 1'b0;
      lcd_en_q    <= 1'b0;
`ifdef LCD_INIT_EN
      init_idx_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_byte_q  <= cur_byte_d;
      cur_rs_q    <= cur_rs_d;
      hold_vld_q  <= hold_vld_d;
      hold_byte_q <= hold_byte_d;
      hold_rs_q   <= hold_rs_d;
      ovf_q       <= ovf_d;
      lcd_on_q    <= lcd_on_d;
      lcd_en_q    <= lcd_en_d;
`ifdef LCD_INIT_EN
      init_idx_q  <= init_idx_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
    cur_byte_d  = cur_byte_q;
    cur_rs_d    = cur_rs_q;
    hold_vld_d  = hold_vld_q;
    hold_byte_d = hold_byte_q;
    hold_rs_d   = hold_rs_q;
    ovf_d       = ovf_q;
    lcd_on_d    = lcd_on_q;
`ifdef LCD_INIT_EN
    init_idx_d  = init_idx_q;
`endif

    case (state_q)
      ST_IDLE: begin
`ifdef LCD_INIT_EN
        if (init_pend) begin
          cur_byte_d = init_byte;
          cur_rs_d   = 1'b0;
          init_idx_d = init_idx_q + 3'd1;
          state_d    = ST_SETUP;
          cnt_d      = CNT_SETUP;
        end else
`endif
        if (hold_vld_q) begin
          cur_byte_d = hold_byte_q;
          cur_rs_d   = hold_rs_q;
          hold_vld_d = 1'b0;
          state_d    = ST_SETUP;
          cnt_d      = CNT_SETUP;
        end else if (wr_direct) begin
          cur_byte_d = i_wr_data[7:0];
          cur_rs_d   = i_wr_data[8];
          state_d    = ST_SETUP;
          cnt_d      = CNT_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_PULSE;
          cnt_d   = CNT_PW;
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_WAIT;
          cnt_d   = long_wait ? CNT_EXEC_LONG : CNT_EXEC;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
`ifdef LCD_INIT_EN
      ST_INIT_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Clear first so a simultaneous drop leaves the flag set.
    if (i_stat_clr) ovf_d = 1'b0;

    if (i_wr_en) begin
      lcd_on_d = i_wr_data[31];
      if (!wr_direct) begin
        if (hold_free) begin
          hold_vld_d  = 1'b1;
          hold_byte_d = i_wr_data[7:0];
          hold_rs_d   = i_wr_data[8];
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    lcd_en_d = (state_d == ST_PULSE);
    busy     = (state_q != ST_IDLE) || hold_vld_q || init_pend;
  end

  assign o_status   = {30'b0, ovf_q, busy};
  assign o_lcd_data = cur_byte_q;
  assign o_lcd_rs   = cur_rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = lcd_en_q;
  assign o_lcd_on   = lcd_on_q;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed bench for lcd_hd44780_ctrl; T_EXEC_LONG is shortened so the run stays short.
module tb_lcd_hd44780_ctrl;

  localparam int TS = 4;
  localparam int TP = 12;
  localparam int TH = 4;
  localparam int TE = 1850;
  localparam int TL = 3000;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        stat_clr;
  logic [31:0] status;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en, lcd_on;

  int n_cmp;
  int n_fail;

  int         obs_np;
  int         obs_end;
  int         obs_rw_bad;
  int         obs_rise[4];
  int         obs_pw[4];
  logic [7:0] obs_data[4];
  logic       obs_rs[4];

  lcd_hd44780_ctrl #(
    .T_SETUP(TS), .T_PW(TP), .T_HOLD(TH), .T_EXEC(TE), .T_EXEC_LONG(TL), .T_POWERUP(100)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .i_stat_clr(stat_clr), .o_status(status), .o_lcd_data(lcd_data), .o_lcd_rs(lcd_rs),
    .o_lcd_rw(lcd_rw), .o_lcd_en(lcd_en), .o_lcd_on(lcd_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle store strobe, issued from a falling edge.
  task automatic issue(input logic [31:0] w, input logic clr);
    wr_data  = w;
    wr_en    = 1'b1;
    stat_clr = clr;
    @(negedge clk);
    wr_en    = 1'b0;
    wr_data  = '0;
    stat_clr = 1'b0;
  endtask

  // Sample on falling edges from index 'start' until busy drops or the budget runs out.
  task automatic observe(input int start, input int budget);
    logic prev_en;
    prev_en    = 1'b0;
    obs_np     = 0;
    obs_end    = -1;
    obs_rw_bad = 0;
    for (int k = 0; k < 4; k++) begin
      obs_rise[k] = -1; obs_pw[k] = 0; obs_data[k] = '0; obs_rs[k] = 1'b0;
    end
    for (int i = start; i < start + budget; i++) begin
      if (lcd_rw !== 1'b0) obs_rw_bad++;
      if (lcd_en && !prev_en && obs_np < 4) begin
        obs_rise[obs_np] = i;
        obs_data[obs_np] = lcd_data;
        obs_rs[obs_np]   = lcd_rs;
        obs_np++;
      end
      if (lcd_en && obs_np > 0) obs_pw[obs_np-1]++;
      prev_en = lcd_en;
      if (status[0] == 1'b0) begin
        obs_end = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({status, lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: status=%h data=%h rs=%b rw=%b en=%b on=%b, want all 0",
               status, lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (status !== 32'h0 || lcd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: status=%h en=%b, want 0/0", status, lcd_en);
    end
    $display("reset: released, status=%h", status);
  endtask

  task automatic test_single_write();
    issue(32'h8000_0141, 1'b0);
    observe(1, 4000);
    n_cmp++;
    if (lcd_on !== 1'b1) begin n_fail++; $display("FAIL single_on: got %b want 1", lcd_on); end
    n_cmp++;
    if (obs_np !== 1 || obs_data[0] !== 8'h41 || obs_rs[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_bus: pulses=%0d data=%h rs=%b, want 1/41/1", obs_np, obs_data[0], obs_rs[0]);
    end
    n_cmp++;
    if (obs_rise[0] !== TS + 1 || obs_pw[0] !== TP) begin
      n_fail++;
      $display("FAIL single_en: rise=%0d width=%0d, want %0d/%0d", obs_rise[0], obs_pw[0], TS + 1, TP);
    end
    n_cmp++;
    if (obs_end !== 1 + TS + TP + TH + TE) begin
      n_fail++;
      $display("FAIL single_busy: busy end=%0d want %0d", obs_end, 1 + TS + TP + TH + TE);
    end
    n_cmp++;
    if (obs_rw_bad !== 0 || lcd_data !== 8'h41 || lcd_rs !== 1'b1) begin
      n_fail++;
      $display("FAIL single_idle_bus: rw_bad=%0d data=%h rs=%b, want 0/41/1", obs_rw_bad, lcd_data, lcd_rs);
    end
    $display("single: data=%h rise=%0d width=%0d busy_end=%0d", obs_data[0], obs_rise[0], obs_pw[0], obs_end);
  endtask

  task automatic test_exec_time();
    logic [31:0] words[6];
    int          waits[6];
    words = '{32'h0000_0001, 32'h0000_0038, 32'h0000_0003, 32'h0000_0004, 32'h0000_0100, 32'h0000_0000};
    waits = '{TL, TE, TL, TE, TE, TL};
    for (int t = 0; t < 6; t++) begin
      issue(words[t], 1'b0);
      observe(1, 4000);
      n_cmp++;
      if (obs_end !== 1 + TS + TP + TH + waits[t] || obs_data[0] !== words[t][7:0]
          || obs_rs[0] !== words[t][8] || lcd_on !== 1'b0) begin
        n_fail++;
        $display("FAIL exec_%0d: word=%h end=%0d data=%h rs=%b on=%b, want end=%0d data=%h rs=%b on=0",
                 t, words[t], obs_end, obs_data[0], obs_rs[0], lcd_on,
                 1 + TS + TP + TH + waits[t], words[t][7:0], words[t][8]);
      end
      $display("exec: word=%h wait=%0d busy_end=%0d", words[t], obs_end - 1 - TS - TP - TH, obs_end);
    end
  endtask

  task automatic test_back_to_back();
    issue(32'h0000_0141, 1'b0);
    issue(32'h0000_0142, 1'b0);
    issue(32'h0000_0143, 1'b0);
    n_cmp++;
    if (status !== 32'h3) begin n_fail++; $display("FAIL b2b_status: got %h want 3", status); end
    issue(32'h0, 1'b0);
    wr_en = 1'b0;
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    n_cmp++;
    if (status !== 32'h1) begin n_fail++; $display("FAIL b2b_clr: got %h want 1", status); end
    observe(5, 8000);
    n_cmp++;
    if (obs_np !== 2 || obs_data[0] !== 8'h41 || obs_data[1] !== 8'h42) begin
      n_fail++;
      $display("FAIL b2b_order: pulses=%0d d0=%h d1=%h, want 2/41/42", obs_np, obs_data[0], obs_data[1]);
    end
    n_cmp++;
    if (obs_rise[1] - obs_rise[0] !== TP + TH + TE + 1 + TS || obs_pw[1] !== TP) begin
      n_fail++;
      $display("FAIL b2b_spacing: gap=%0d width=%0d, want %0d/%0d",
               obs_rise[1] - obs_rise[0], obs_pw[1], TP + TH + TE + 1 + TS, TP);
    end
    n_cmp++;
    if (status !== 32'h0 || obs_end < 0) begin
      n_fail++;
      $display("FAIL b2b_done: status=%h end=%0d, want 0 and finished", status, obs_end);
    end
    $display("b2b: d0=%h d1=%h gap=%0d status=%h", obs_data[0], obs_data[1], obs_rise[1] - obs_rise[0], status);
  endtask

  task automatic test_ovf_clr_race();
    issue(32'h0000_0141, 1'b0);
    issue(32'h0000_0142, 1'b0);
    issue(32'h0000_0143, 1'b1);
    n_cmp++;
    if (status !== 32'h3) begin n_fail++; $display("FAIL race_ovf: got %h want 3", status); end
    observe(3, 8000);
    n_cmp++;
    if (status !== 32'h2 || obs_np !== 2) begin
      n_fail++;
      $display("FAIL race_sticky: status=%h pulses=%0d, want 2/2", status, obs_np);
    end
    issue(32'h0, 1'b0);
    wr_en = 1'b0;
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    // The zero-word store above started a long command; let it finish.
    observe(0, 4000);
    n_cmp++;
    if (status !== 32'h0) begin n_fail++; $display("FAIL race_clear: got %h want 0", status); end
    $display("race: ovf survived same-cycle clear, status now %h", status);
  endtask

  task automatic test_reset_in_pulse();
    issue(32'h8000_0141, 1'b0);
    issue(32'h8000_0142, 1'b0);
    repeat (6) @(negedge clk);
    n_cmp++;
    if (lcd_en !== 1'b1 || status !== 32'h1) begin
      n_fail++;
      $display("FAIL rstp_pre: en=%b status=%h, want 1/1", lcd_en, status);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({status, lcd_data, lcd_rs, lcd_en, lcd_on} !== '0) begin
      n_fail++;
      $display("FAIL rstp_async: status=%h data=%h rs=%b en=%b on=%b, want all 0",
               status, lcd_data, lcd_rs, lcd_en, lcd_on);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(32'h8000_0155, 1'b0);
    observe(1, 4000);
    n_cmp++;
    if (obs_np !== 1 || obs_data[0] !== 8'h55 || obs_rise[0] !== TS + 1
        || obs_end !== 1 + TS + TP + TH + TE || lcd_on !== 1'b1) begin
      n_fail++;
      $display("FAIL rstp_fresh: pulses=%0d data=%h rise=%0d end=%0d on=%b, want 1/55/%0d/%0d/1",
               obs_np, obs_data[0], obs_rise[0], obs_end, lcd_on, TS + 1, 1 + TS + TP + TH + TE);
    end
    $display("rst_pulse: fresh cycle data=%h pulses=%0d", obs_data[0], obs_np);
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_data  = '0;
    stat_clr = 1'b0;
    test_reset();
    test_single_write();
    test_exec_time();
    test_back_to_back();
    test_ovf_clr_race();
    test_reset_in_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
